// File: rtl/fifo_rd_burst_if.sv
// Handshake bundle between a burst reader and its FIFO source / byte sink.
interface fifo_rd_burst_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  burst_len;
  logic              rempty;
  logic [DATA_W-1:0] rdata;
  logic              rinc;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] csum;

  modport master (
    output start, burst_len, rempty, rdata, out_ready,
    input  rinc, out_data, out_valid, busy, done, csum
  );

  modport slave (
    input  start, burst_len, rempty, rdata, out_ready,
    output rinc, out_data, out_valid, busy, done, csum
  );
endinterface

// File: rtl/fifo_rd_burst.sv
// Reads a fixed-length burst from a FIFO into a 2-entry output buffer,
// accumulating a modular byte checksum and pulsing done on completion.
module fifo_rd_burst #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic           i_rclk,
  input  logic           i_rrst,
  fifo_rd_burst_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [LEN_W:0]    r_remaining, w_remaining_next;
  logic [1:0]        r_count, w_count_next;
  logic [DATA_W-1:0] r_buf0, r_buf1, r_csum;
  logic              w_push, w_pop, w_start_acc;
  logic              w_rinc, w_busy, w_done;

  assign w_start_acc      = (r_state == StIdle) && bus.start;
  assign w_push           = w_rinc;
  assign w_pop            = (r_count != 2'd0) && bus.out_ready;
  assign w_remaining_next = w_push ? (r_remaining - (LEN_W+1)'(1)) : r_remaining;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (bus.start) w_state_next = StRun;
      StRun: begin
        if (w_remaining_next == '0) begin
          w_state_next = (w_count_next == 2'd0) ? StDone : StDrain;
        end
      end
      StDrain: if (w_count_next == 2'd0) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_rinc = (r_state == StRun) && !bus.rempty && (r_remaining != '0) && (r_count < 2'd2);
    w_busy = (r_state == StRun) || (r_state == StDrain);
    w_done = (r_state == StDone);
  end

  always_ff @(posedge i_rclk) begin
    if (i_rrst) begin
      r_count     <= 2'd0;
      r_remaining <= '0;
      r_csum      <= '0;
      r_buf0      <= '0;
      r_buf1      <= '0;
    end else begin
      r_count     <= w_count_next;
      r_remaining <= w_remaining_next;
      if (w_start_acc) begin
        // Length 0 encodes a full 2^LEN_W-byte burst.
        r_remaining <= (bus.burst_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, bus.burst_len};
        r_csum      <= '0;
      end else if (w_push) begin
        r_csum <= r_csum + bus.rdata;
      end
      if (w_pop) begin
        r_buf0 <= (w_push && (r_count == 2'd1)) ? bus.rdata : r_buf1;
        if (w_push && (r_count == 2'd2)) r_buf1 <= bus.rdata;
      end else if (w_push) begin
        if (r_count == 2'd0) r_buf0 <= bus.rdata;
        else                 r_buf1 <= bus.rdata;
      end
    end
  end

  assign bus.rinc      = w_rinc;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_data  = r_buf0;
  assign bus.csum      = r_csum;
endmodule

// File: tb/tb_fifo_rd_burst.sv
// Bench for fifo_rd_burst: FIFO source and sink models plus a cycle-level reference model.
module tb_fifo_rd_burst;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_burst_if #(.DATA_W(8), .LEN_W(8)) bus ();
  fifo_rd_burst #(.DATA_W(8), .LEN_W(8)) dut (
    .i_rclk (clk),
    .i_rrst (rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fifo_q[$];
  logic       g_start, g_ready, g_stall, g_rst;
  logic [7:0] g_len;

  // Reference model: phase 0 idle, 1 burst active, 2 done pulse.
  int         m_phase;
  int         m_rem;
  logic [7:0] m_buf[$];
  logic [7:0] m_csum;
  bit         m_known = 1'b0;

  int pops = 0, dones = 0, cyc = 0, first_pop = -1, last_pop = -1;

  typedef struct {
    logic [7:0] len;
    int         nbytes;
    logic [7:0] base;
    logic [7:0] stride;
    logic [7:0] exp_csum;
    int         exp_pops;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic       e_rinc, e_valid, s_rinc, s_done, m_pop;
    logic [7:0] din;
    rst            = g_rst;
    bus.start      = g_start;
    bus.burst_len  = g_len;
    bus.out_ready  = g_ready;
    bus.rempty     = g_stall || (fifo_q.size() == 0);
    din            = bus.rempty ? 8'($urandom) : fifo_q[0];
    bus.rdata      = din;
    #1;
    e_rinc  = (m_phase == 1) && (m_rem != 0) && !bus.rempty && (m_buf.size() < 2);
    e_valid = (m_buf.size() != 0);
    if (m_known) begin
      chk("rinc", 32'(bus.rinc), 32'(e_rinc));
      chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
      if (e_valid) chk("out_data", 32'(bus.out_data), 32'(m_buf[0]));
      chk("busy", 32'(bus.busy), 32'(m_phase == 1));
      chk("done", 32'(bus.done), 32'(m_phase == 2));
      chk("csum", 32'(bus.csum), 32'(m_csum));
    end
    s_rinc = bus.rinc;
    s_done = bus.done;
    @(posedge clk);
    cyc++;
    if (s_rinc) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (s_done) dones++;
    if (g_rst) begin
      m_phase = 0; m_rem = 0; m_csum = 8'h00; m_buf.delete(); m_known = 1'b1;
    end else begin
      case (m_phase)
        0: if (g_start) begin
          m_phase = 1;
          m_rem   = (g_len == 8'd0) ? 256 : int'(g_len);
          m_csum  = 8'h00;
        end
        1: begin
          m_pop = e_valid && g_ready;
          if (m_pop) void'(m_buf.pop_front());
          if (e_rinc) begin
            m_buf.push_back(din);
            m_rem--;
            m_csum = m_csum + din;
          end
          if (m_rem == 0 && m_buf.size() == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic wait_done(input int d0, input int budget, input bit rnd);
    for (int i = 0; i < budget && dones == d0; i++) begin
      if (rnd) begin
        g_ready = 1'($urandom_range(0, 1));
        g_stall = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1 && fifo_q.size() < 4) fifo_q.push_back(8'($urandom));
      end
      step();
    end
    chk("burst_done", 32'(dones - d0), 32'd1);
  endtask

  task automatic run_burst(input logic [7:0] len, input bit rnd, input int budget,
                           output int n_pops, output int n_done);
    int p0, d0;
    p0 = pops; d0 = dones; first_pop = -1; last_pop = -1;
    g_len = len; g_start = 1'b1;
    step();
    g_start = 1'b0;
    wait_done(d0, budget, rnd);
    step();
    n_pops = pops - p0;
    n_done = dones - d0;
  endtask

  initial begin
    int np, nd, p0, d0;
    logic [7:0] len;

    vecs[0] = '{len: 8'd3, nbytes: 3,   base: 8'h11, stride: 8'h11, exp_csum: 8'h66, exp_pops: 3};
    vecs[1] = '{len: 8'd1, nbytes: 2,   base: 8'h80, stride: 8'h00, exp_csum: 8'h80, exp_pops: 1};
    vecs[2] = '{len: 8'd5, nbytes: 5,   base: 8'h01, stride: 8'h01, exp_csum: 8'h0F, exp_pops: 5};
    vecs[3] = '{len: 8'd2, nbytes: 2,   base: 8'hFF, stride: 8'h03, exp_csum: 8'h01, exp_pops: 2};
    vecs[4] = '{len: 8'd4, nbytes: 6,   base: 8'h40, stride: 8'h40, exp_csum: 8'h80, exp_pops: 4};
    vecs[5] = '{len: 8'd0, nbytes: 300, base: 8'h01, stride: 8'h00, exp_csum: 8'h00, exp_pops: 256};

    g_start = 1'b0; g_ready = 1'b1; g_stall = 1'b0; g_rst = 1'b1; g_len = 8'd0;
    m_phase = 0; m_rem = 0; m_csum = 8'h00;
    repeat (2) step();
    g_rst = 1'b0;
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_csum", 32'(bus.csum), 32'h0);
    step();

    foreach (vecs[i]) begin
      fifo_q.delete();
      for (int k = 0; k < vecs[i].nbytes; k++) fifo_q.push_back(8'(vecs[i].base + k * vecs[i].stride));
      g_ready = 1'b1; g_stall = 1'b0;
      run_burst(vecs[i].len, 1'b0, 600, np, nd);
      chk("vec_csum", 32'(bus.csum), 32'(vecs[i].exp_csum));
      chk("vec_pops", 32'(np), 32'(vecs[i].exp_pops));
      chk("vec_consecutive", 32'(last_pop - first_pop + 1), 32'(vecs[i].exp_pops));
      chk("vec_left", 32'(fifo_q.size()), 32'(vecs[i].nbytes - vecs[i].exp_pops));
    end

    // Sink back-pressure: only two bytes fit, head held until ready returns.
    fifo_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    p0 = pops; d0 = dones; g_ready = 1'b0; g_len = 8'd4; g_start = 1'b1;
    step();
    g_start = 1'b0;
    repeat (8) step();
    chk("bp_pops", 32'(pops - p0), 32'd2);
    chk("bp_head", 32'(bus.out_data), 32'hA1);
    chk("bp_rinc", 32'(bus.rinc), 32'h0);
    g_ready = 1'b1;
    wait_done(d0, 50, 1'b0);
    chk("bp_total", 32'(pops - p0), 32'd4);
    step();

    // Empty FIFO stalls the burst, then wrapping checksum.
    fifo_q = '{8'hFF, 8'h02};
    p0 = pops; d0 = dones; g_stall = 1'b1; g_len = 8'd2; g_start = 1'b1;
    step();
    g_start = 1'b0;
    repeat (5) step();
    chk("stall_pops", 32'(pops - p0), 32'd0);
    chk("stall_busy", 32'(bus.busy), 32'h1);
    g_stall = 1'b0;
    wait_done(d0, 50, 1'b0);
    chk("stall_csum", 32'(bus.csum), 32'h01);
    step();

    // Start pulsed mid-burst is ignored.
    fifo_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    p0 = pops; d0 = dones; g_len = 8'd3; g_start = 1'b1;
    step();
    g_start = 1'b0;
    step();
    g_start = 1'b1; g_len = 8'd7;
    step();
    g_start = 1'b0;
    wait_done(d0, 50, 1'b0);
    chk("restart_pops", 32'(pops - p0), 32'd3);
    chk("restart_left", 32'(fifo_q.size()), 32'd4);
    chk("restart_csum", 32'(bus.csum), 32'd6);
    step();

    // Reset mid-burst discards buffered data, no done pulse.
    fifo_q = '{8'h10, 8'h20, 8'h30};
    p0 = pops; d0 = dones; g_len = 8'd3; g_start = 1'b1;
    step();
    g_start = 1'b0;
    step();
    chk("mid_rst_pops", 32'(pops - p0), 32'd1);
    g_rst = 1'b1; g_stall = 1'b1;
    step();
    g_rst = 1'b0; g_stall = 1'b0;
    chk("mid_rst_rinc", 32'(bus.rinc), 32'h0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_csum", 32'(bus.csum), 32'h0);
    repeat (5) step();
    chk("mid_rst_no_done", 32'(dones - d0), 32'd0);

    // Random bursts with random back-pressure and FIFO starvation.
    repeat (25) begin
      fifo_q.delete();
      repeat ($urandom_range(0, 4)) fifo_q.push_back(8'($urandom));
      len = 8'($urandom_range(1, 8));
      g_ready = 1'b1; g_stall = 1'b0;
      run_burst(len, 1'b1, 2000, np, nd);
      chk("rnd_pops", 32'(np), 32'(len));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
